// File: rtl/playfield_pkg.sv
// Shared encodings for the playfield engine: command ops, FSM states, score table.
// Scoring is built only when PLAYFIELD_SCORE_EN is defined.
package playfield_pkg;

  typedef enum logic [1:0] {
    OP_QUERY = 2'd0,
    OP_LOCK  = 2'd1,
    OP_CLEAR = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUERY,
    S_LOCK,
    S_SCAN,
    S_SHIFT,
    S_DONE
  } state_e;

  localparam logic [3:0] SCORE_TBL [5] = '{
    4'd0, 4'd1, 4'd3, 4'd5, 4'd8
  };

  function automatic logic [3:0] score_pts(input logic [2:0] n);
    if (n >= 3'd4) return SCORE_TBL[4];
    return SCORE_TBL[n];
  endfunction

endpackage

// File: rtl/playfield_scorer.sv
// Saturating score accumulator fed by the lines-cleared table.
// Only present when PLAYFIELD_SCORE_EN is defined.
`ifdef PLAYFIELD_SCORE_EN
module playfield_scorer
  import playfield_pkg::*;
#(
  parameter int SCORE_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic               i_add,
  input  logic [2:0]         i_lines,
  output logic [SCORE_W-1:0] o_score
);

  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W:0]   w_sum;

  assign w_sum = {1'b0, r_score}
               + (SCORE_W+1)'(score_pts(i_lines));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_score <= '0;
    end else if (i_clr) begin
      r_score <= '0;
    end else if (i_add) begin
      r_score <= w_sum[SCORE_W] ? '1
                                : w_sum[SCORE_W-1:0];
    end
  end

  assign o_score = r_score;

endmodule
`endif

// File: rtl/playfield_engine.sv
// Falling-block playfield: collision query, lock, line scan/shift, top-out.
// Define PLAYFIELD_SCORE_EN to build the score counter.
module playfield_engine
  import playfield_pkg::*;
#(
  parameter  int W       = 8,
  parameter  int H       = 8,
  parameter  int SCORE_W = 16,
  localparam int RW      = $clog2(H)
) (
  input  logic               CLK,
  input  logic               CLR,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [RW-1:0]      cmd_row,
  input  logic [4*W-1:0]     cmd_mask,
  output logic               rsp_valid,
  output logic               rsp_hit,
  output logic [2:0]         lines_cleared,
  output logic [SCORE_W-1:0] score,
  output logic               game_over,
  input  logic [RW-1:0]      rd_row,
  output logic [W-1:0]       rd_data
);

  state_e         r_state;
  state_e         w_next;
  op_e            r_op;
  logic [RW-1:0]  r_row;
  logic [4*W-1:0] r_mask;
  logic [W-1:0]   r_field [H];
  logic [RW-1:0]  r_scan;
  logic [2:0]     r_cnt;
  logic           r_hit;
  logic [2:0]     r_lines;
  logic           r_go;
  logic [W-1:0]   r_rd;

  logic w_accept;
  logic w_row_full;
  logic w_next_full;
  logic w_hit;

  assign w_accept   = cmd_valid && (r_state == S_IDLE);
  assign w_row_full = &r_field[r_scan];
  // Row landing at r_scan after a shift; checking it here avoids a rescan.
  assign w_next_full = (r_scan != '0)
                    && (&r_field[r_scan - 1'b1]);

  always_comb begin
    w_hit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (int'(r_row) + k >= H)
        w_hit = w_hit | (|r_mask[k*W +: W]);
      else
        w_hit = w_hit
              | (|(r_field[RW'(int'(r_row) + k)]
                   & r_mask[k*W +: W]));
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          unique case (1'b1)
            cmd_op == OP_LOCK:  w_next = S_LOCK;
            cmd_op == OP_CLEAR: w_next = S_DONE;
            default:            w_next = S_QUERY;
          endcase
        end
      end
      S_QUERY: w_next = S_DONE;
      S_LOCK:  w_next = r_go ? S_DONE : S_SCAN;
      S_SCAN: begin
        if (w_row_full)           w_next = S_SHIFT;
        else if (r_scan == '0)    w_next = S_DONE;
      end
      S_SHIFT: begin
        if (w_next_full)          w_next = S_SHIFT;
        else if (r_scan == '0)    w_next = S_DONE;
        else                      w_next = S_SCAN;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      for (int i = 0; i < H; i++) r_field[i] <= '0;
      r_op    <= OP_QUERY;
      r_row   <= '0;
      r_mask  <= '0;
      r_scan  <= '0;
      r_cnt   <= '0;
      r_hit   <= 1'b0;
      r_lines <= '0;
      r_go    <= 1'b0;
      r_rd    <= '0;
    end else begin
      r_rd <= (int'(rd_row) < H) ? r_field[rd_row] : '0;
      if (w_accept) begin
        r_row  <= cmd_row;
        r_mask <= cmd_mask;
        unique case (1'b1)
          cmd_op == OP_LOCK:  r_op <= OP_LOCK;
          cmd_op == OP_CLEAR: r_op <= OP_CLEAR;
          default:            r_op <= OP_QUERY;
        endcase
        if (cmd_op == OP_CLEAR) begin
          for (int i = 0; i < H; i++) r_field[i] <= '0;
          r_go <= 1'b0;
        end
      end
      case (r_state)
        S_QUERY: r_hit <= w_hit | r_go;
        S_LOCK: begin
          r_scan <= RW'(H - 1);
          r_cnt  <= '0;
          if (r_go) begin
            r_hit   <= 1'b1;
            r_lines <= '0;
          end else begin
            for (int k = 0; k < 4; k++) begin
              if (int'(r_row) + k < H)
                r_field[RW'(int'(r_row) + k)] <=
                  r_field[RW'(int'(r_row) + k)]
                  | r_mask[k*W +: W];
            end
          end
        end
        S_SCAN: begin
          if (!w_row_full) begin
            if (r_scan == '0) r_lines <= r_cnt;
            else              r_scan  <= r_scan - 1'b1;
          end
        end
        S_SHIFT: begin
          r_field[0] <= '0;
          for (int i = 1; i < H; i++) begin
            if (i <= int'(r_scan))
              r_field[i] <= r_field[i-1];
          end
          r_cnt <= r_cnt + 3'd1;
          if (!w_next_full) begin
            if (r_scan == '0) r_lines <= r_cnt + 3'd1;
            else              r_scan  <= r_scan - 1'b1;
          end
        end
        S_DONE: begin
          if (r_op == OP_LOCK && (|r_field[0]))
            r_go <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef PLAYFIELD_SCORE_EN
  logic w_score_clr;
  logic w_score_add;

  assign w_score_clr = w_accept && (cmd_op == OP_CLEAR);
  assign w_score_add = (r_state == S_DONE)
                    && (r_op == OP_LOCK);

  playfield_scorer #(
    .SCORE_W (SCORE_W)
  ) u_scorer (
    .i_clk   (CLK),
    .i_rst_n (CLR),
    .i_clr   (w_score_clr),
    .i_add   (w_score_add),
    .i_lines (r_lines),
    .o_score (score)
  );
`else
  assign score = '0;
`endif

  assign cmd_ready     = (r_state == S_IDLE);
  assign rsp_valid     = (r_state == S_DONE);
  assign rsp_hit       = r_hit;
  assign lines_cleared = r_lines;
  assign game_over     = r_go;
  assign rd_data       = r_rd;

endmodule

// File: tb/tb_playfield_engine.sv
// Directed bench for playfield_engine on an 8x8 field.
// Score expectations follow PLAYFIELD_SCORE_EN.
module tb_playfield_engine;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int SW = 16;
`ifdef PLAYFIELD_SCORE_EN
  localparam bit SC_EN = 1'b1;
`else
  localparam bit SC_EN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          CLR = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [2:0]    cmd_row = '0;
  logic [4*W-1:0] cmd_mask = '0;
  logic          rsp_valid;
  logic          rsp_hit;
  logic [2:0]    lines_cleared;
  logic [SW-1:0] score;
  logic          game_over;
  logic [2:0]    rd_row = '0;
  logic [W-1:0]  rd_data;

  int n_chk = 0;
  int n_err = 0;
  int lat;
  int seen;
  logic [W-1:0] acc;

  always #5 CLK = ~CLK;

  playfield_engine #(
    .W(W), .H(H), .SCORE_W(SW)
  ) dut (
    .CLK           (CLK),
    .CLR           (CLR),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_row       (cmd_row),
    .cmd_mask      (cmd_mask),
    .rsp_valid     (rsp_valid),
    .rsp_hit       (rsp_hit),
    .lines_cleared (lines_cleared),
    .score         (score),
    .game_over     (game_over),
    .rd_row        (rd_row),
    .rd_data       (rd_data)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sc(input int v);
    return SC_EN ? 32'(v) : 32'd0;
  endfunction

  // Issue one command; returns cycles from accept to rsp_valid (0 = timeout).
  task automatic cmd(input logic [1:0] op, input int row,
                     input logic [31:0] mask,
                     output int lt);
    @(negedge CLK);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_row   = 3'(row);
    cmd_mask  = mask;
    @(posedge CLK);
    #1 cmd_valid = 1'b0;
    lt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      if (rsp_valid) begin
        lt = i;
        break;
      end
    end
  endtask

  task automatic rd(input int row, output logic [W-1:0] d);
    @(negedge CLK);
    rd_row = 3'(row);
    @(negedge CLK);
    d = rd_data;
  endtask

  task automatic field_or(output logic [W-1:0] a);
    logic [W-1:0] d;
    a = '0;
    for (int r = 0; r < H; r++) begin
      rd(r, d);
      a = a | d;
    end
  endtask

  initial begin
    logic [W-1:0] d;
    #12 CLR = 1'b1;
    @(negedge CLK);
    check("rst_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_hit", rsp_hit, 0);
    check("rst_lines", lines_cleared, 0);
    check("rst_score", score, 0);
    check("rst_go", game_over, 0);
    check("rst_rd", rd_data, 0);

    cmd(2'd0, 6, 32'h0000_00F0, lat);
    check("q_empty_lat", lat, 2);
    check("q_empty_hit", rsp_hit, 0);
    @(negedge CLK);
    check("q_pulse_one", rsp_valid, 0);

    cmd(2'd1, 7, 32'h0000_00FF, lat);
    check("lock1_lat", lat, 11);
    check("lock1_lines", lines_cleared, 1);
    @(negedge CLK);
    check("lock1_score", score, sc(1));
    check("lock1_go", game_over, 0);
    field_or(acc);
    check("lock1_field", acc, 0);

    cmd(2'd1, 5, 32'h0000_0018, lat);
    check("lock_nc_lat", lat, 10);
    check("lock_nc_lines", lines_cleared, 0);
    rd(5, d);
    check("lock_nc_row5", d, 8'h18);
    cmd(2'd0, 5, 32'h0000_0008, lat);
    check("q_col_hit", rsp_hit, 1);
    cmd(2'd3, 4, 32'h0000_8100, lat);
    check("q_rsvd_lat", lat, 2);
    check("q_miss_hit", rsp_hit, 0);

    cmd(2'd2, 0, 32'h0, lat);
    check("clr_lat", lat, 1);
    @(negedge CLK);
    check("clr_score", score, 0);
    cmd(2'd1, 6, 32'h0000_FEFE, lat);
    check("preset_lines", lines_cleared, 0);
    cmd(2'd1, 6, 32'h0000_0101, lat);
    check("two_lat", lat, 12);
    check("two_lines", lines_cleared, 2);
    @(negedge CLK);
    check("two_score", score, sc(3));
    field_or(acc);
    check("two_field", acc, 0);

    cmd(2'd0, 7, 32'h0000_8000, lat);
    check("floor_hit", rsp_hit, 1);

    cmd(2'd1, 0, 32'h0000_0080, lat);
    check("top_lat", lat, 10);
    @(negedge CLK);
    check("top_go", game_over, 1);
    cmd(2'd0, 4, 32'h0000_00F0, lat);
    check("go_q_hit", rsp_hit, 1);
    cmd(2'd1, 3, 32'h0000_00FF, lat);
    check("go_lock_rsp", lat != 0, 1);
    check("go_lock_lines", lines_cleared, 0);
    rd(3, d);
    check("go_lock_row3", d, 0);
    check("go_score_held", score, sc(3));
    cmd(2'd2, 0, 32'h0, lat);
    @(negedge CLK);
    check("clr_go", game_over, 0);
    check("clr_score2", score, 0);
    rd(0, d);
    check("clr_row0", d, 0);

    cmd(2'd1, 7, 32'h0000_00FF, lat);
    check("pre_rst_lines", lines_cleared, 1);
    @(negedge CLK);
    rd_row = 3'd7;
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    cmd_row   = 3'd7;
    cmd_mask  = 32'h0000_00FF;
    @(posedge CLK);
    #1 cmd_valid = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #2;
    check("mid_rd_pre", rd_data, 8'hFF);
    CLR = 1'b0;
    #1;
    check("mid_rsp_valid", rsp_valid, 0);
    check("mid_hit", rsp_hit, 0);
    check("mid_lines", lines_cleared, 0);
    check("mid_score", score, 0);
    check("mid_go", game_over, 0);
    check("mid_rd", rd_data, 0);
    @(negedge CLK);
    CLR = 1'b1;
    @(negedge CLK);
    check("rel_ready", cmd_ready, 1);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      if (rsp_valid) seen++;
    end
    check("rel_no_rsp", seen, 0);
    rd(7, d);
    check("rel_row7", d, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
